// File: rtl/elevator_floor_ctrl_pkg.sv
// Shared types and floor helpers for the three-floor elevator sequencer.
package elevator_pkg;

    localparam int NUM_FLOORS = 3;

    typedef logic [1:0]            floor_t;
    typedef logic [NUM_FLOORS-1:0] lamp_t;

    localparam floor_t FLOOR_1ST = 2'b00;
    localparam floor_t FLOOR_2ND = 2'b01;
    localparam floor_t FLOOR_3RD = 2'b10;

    typedef enum logic [1:0] {IDLE, MOVE, DOOR} car_state_t;

    function automatic lamp_t floor_bit(floor_t f);
        return lamp_t'(1) << f;
    endfunction

    function automatic lamp_t floors_above(floor_t f);
        case (f)
            FLOOR_1ST: return 3'b110;
            FLOOR_2ND: return 3'b100;
            default:   return 3'b000;
        endcase
    endfunction

    function automatic lamp_t floors_below(floor_t f);
        case (f)
            FLOOR_2ND: return 3'b001;
            FLOOR_3RD: return 3'b011;
            default:   return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/elevator_floor_ctrl_if.sv
// Call inputs and car status outputs of the elevator sequencer.
interface elevator_floor_ctrl_if;
    import elevator_pkg::*;

    lamp_t  call_i;
    floor_t floor_o;
    logic   moving_o;
    logic   dir_up_o;
    logic   door_open_o;
    lamp_t  lamp_o;

    modport master (output call_i, input floor_o, moving_o, dir_up_o, door_open_o, lamp_o);
    modport slave  (input call_i, output floor_o, moving_o, dir_up_o, door_open_o, lamp_o);

endinterface

// File: rtl/elevator_floor_ctrl_timer.sv
// Loadable down-counter that saturates at zero; times both travel and door dwell.
module elevator_timer #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_value,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (r_count != '0) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/elevator_floor_ctrl.sv
// Three-floor car sequencer: latches calls into lamps, picks stops with a SCAN policy,
// times travel between floors and the door dwell.
module elevator_floor_ctrl
    import elevator_pkg::*;
#(
    parameter int unsigned TRAVEL_CYCLES = 8,
    parameter int unsigned DOOR_CYCLES   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    elevator_floor_ctrl_if.slave  bus
);

    localparam int unsigned MAX_CYCLES = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int unsigned TIMER_W    = $clog2(MAX_CYCLES);
    localparam logic [TIMER_W-1:0] TRAVEL_LOAD = TIMER_W'(TRAVEL_CYCLES - 1);
    localparam logic [TIMER_W-1:0] DOOR_LOAD   = TIMER_W'(DOOR_CYCLES - 1);

    car_state_t r_state;
    floor_t     r_floor;
    logic       r_dir_up;
    logic       r_moving;
    logic       r_door;
    lamp_t      r_lamp;

    car_state_t         w_next_state;
    floor_t             w_next_floor;
    logic               w_next_dir;
    lamp_t              w_clr;
    logic               w_load;
    logic [TIMER_W-1:0] w_load_val;
    logic               w_timer_zero;

    logic   w_here;
    logic   w_above;
    logic   w_below;
    floor_t w_step_floor;
    logic   w_arrive_hit;
    logic   w_ahead_after_step;

    assign w_here       = |(r_lamp & floor_bit(r_floor));
    assign w_above      = |(r_lamp & floors_above(r_floor));
    assign w_below      = |(r_lamp & floors_below(r_floor));
    assign w_step_floor = r_dir_up ? r_floor + 2'd1 : r_floor - 2'd1;
    assign w_arrive_hit = |(r_lamp & floor_bit(w_step_floor));
    assign w_ahead_after_step =
        |(r_lamp & (r_dir_up ? floors_above(w_step_floor) : floors_below(w_step_floor)));

    elevator_timer #(.WIDTH(TIMER_W)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load),
        .i_value (w_load_val),
        .o_zero  (w_timer_zero)
    );

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_next_floor = r_floor;
        w_next_dir   = r_dir_up;
        w_clr        = '0;
        w_load       = 1'b0;
        w_load_val   = '0;
        unique case (r_state)
            IDLE: begin
                if (w_here) begin
                    w_next_state = DOOR;
                    w_clr        = floor_bit(r_floor);
                    w_load       = 1'b1;
                    w_load_val   = DOOR_LOAD;
                end else if ((r_dir_up && w_above) || (!r_dir_up && w_below)) begin
                    w_next_state = MOVE;
                    w_load       = 1'b1;
                    w_load_val   = TRAVEL_LOAD;
                end else if (w_above || w_below) begin
                    w_next_dir   = ~r_dir_up;
                    w_next_state = MOVE;
                    w_load       = 1'b1;
                    w_load_val   = TRAVEL_LOAD;
                end
            end
            MOVE: begin
                if (w_timer_zero) begin
                    w_next_floor = w_step_floor;
                    if (w_arrive_hit) begin
                        w_next_state = DOOR;
                        w_clr        = floor_bit(w_step_floor);
                        w_load       = 1'b1;
                        w_load_val   = DOOR_LOAD;
                    end else if (w_ahead_after_step) begin
                        w_load       = 1'b1;
                        w_load_val   = TRAVEL_LOAD;
                    end else begin
                        w_next_state = IDLE;
                    end
                end
            end
            DOOR: begin
                // Calls for the open floor are absorbed and only stretch the dwell.
                w_clr = floor_bit(r_floor);
                if (|(bus.call_i & floor_bit(r_floor))) begin
                    w_load     = 1'b1;
                    w_load_val = DOOR_LOAD;
                end else if (w_timer_zero) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_floor  <= FLOOR_1ST;
            r_dir_up <= 1'b1;
            r_moving <= 1'b0;
            r_door   <= 1'b0;
            r_lamp   <= '0;
        end else begin
            r_state  <= w_next_state;
            r_floor  <= w_next_floor;
            r_dir_up <= w_next_dir;
            r_moving <= (w_next_state == MOVE);
            r_door   <= (w_next_state == DOOR);
            r_lamp   <= (r_lamp | bus.call_i) & ~w_clr;
        end
    end

    assign bus.floor_o     = r_floor;
    assign bus.moving_o    = r_moving;
    assign bus.dir_up_o    = r_dir_up;
    assign bus.door_open_o = r_door;
    assign bus.lamp_o      = r_lamp;

endmodule

// File: tb/tb_elevator_floor_ctrl.sv
// Self-checking bench: directed scenarios with literal expectations, then random calls and
// resets compared every cycle against a remaining-cycles behavioural model of the car.
module tb_elevator_floor_ctrl;
    import elevator_pkg::*;

    localparam int TRAVEL = 8;
    localparam int DWELL  = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   done = 1'b0;

    elevator_floor_ctrl_if bus ();

    elevator_floor_ctrl #(
        .TRAVEL_CYCLES (TRAVEL),
        .DOOR_CYCLES   (DWELL)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: floor number, direction, lamps, and cycles left in the current travel
    // segment or door dwell (zero when not in that activity).
    int       m_floor;
    bit       m_up;
    bit [2:0] m_lamp;
    int       m_move_left;
    int       m_door_left;

    function automatic bit pending(input bit [2:0] lamps, input int f, input bit up);
        for (int g = 0; g < 3; g++)
            if (lamps[g] && (up ? (g > f) : (g < f))) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk) begin : model
        bit [2:0] nl;
        if (!rst_n) begin
            m_floor = 0; m_up = 1'b1; m_lamp = 3'b000;
            m_move_left = 0; m_door_left = 0;
        end else begin
            nl = m_lamp | bus.call_i;
            if (m_door_left > 0) begin
                nl[m_floor] = 1'b0;
                if (bus.call_i[m_floor]) m_door_left = DWELL;
                else m_door_left = m_door_left - 1;
            end else if (m_move_left > 0) begin
                m_move_left = m_move_left - 1;
                if (m_move_left == 0) begin
                    m_floor = m_floor + (m_up ? 1 : -1);
                    if (m_floor >= 0 && m_floor <= 2 && m_lamp[m_floor]) begin
                        m_door_left = DWELL;
                        nl[m_floor] = 1'b0;
                    end else if (pending(m_lamp, m_floor, m_up)) begin
                        m_move_left = TRAVEL;
                    end
                end
            end else begin
                if (m_lamp[m_floor]) begin
                    m_door_left = DWELL;
                    nl[m_floor] = 1'b0;
                end else if (pending(m_lamp, m_floor, m_up)) begin
                    m_move_left = TRAVEL;
                end else if (pending(m_lamp, m_floor, !m_up)) begin
                    m_up = !m_up;
                    m_move_left = TRAVEL;
                end
            end
            m_lamp = nl;
        end
    end

    initial begin : compare
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (!done) begin
                check("floor",     32'(bus.floor_o),     m_floor);
                check("moving",    32'(bus.moving_o),    32'(m_move_left > 0));
                check("door_open", 32'(bus.door_open_o), 32'(m_door_left > 0));
                check("dir_up",    32'(bus.dir_up_o),    32'(m_up));
                check("lamp",      32'(bus.lamp_o),      32'(m_lamp));
                check("floor_range", 32'(bus.floor_o != 2'b11), 32'd1);
            end
        end
    end

    initial begin : stim
        rst_n = 1'b0;
        bus.call_i = 3'b000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("rst_floor",  32'(bus.floor_o),     32'd0);
        check("rst_dir",    32'(bus.dir_up_o),    32'd1);
        check("rst_lamp",   32'(bus.lamp_o),      32'd0);
        check("rst_moving", 32'(bus.moving_o),    32'd0);
        check("rst_door",   32'(bus.door_open_o), 32'd0);

        // Up from 00 to 10 through 01.
        bus.call_i = 3'b100;
        @(negedge clk); bus.call_i = 3'b000;
        check("a_lamp_c1",   32'(bus.lamp_o),   32'h4);
        check("a_moving_c1", 32'(bus.moving_o), 32'd0);
        @(negedge clk);
        check("a_moving_c2", 32'(bus.moving_o), 32'd1);
        repeat (8) @(negedge clk);
        check("a_floor_c10", 32'(bus.floor_o),  32'd1);
        repeat (7) @(negedge clk);
        check("a_moving_c17", 32'(bus.moving_o), 32'd1);
        @(negedge clk);
        check("a_floor_c18", 32'(bus.floor_o),     32'd2);
        check("a_door_c18",  32'(bus.door_open_o), 32'd1);
        check("a_lamp_c18",  32'(bus.lamp_o),      32'd0);
        check("a_move_c18",  32'(bus.moving_o),    32'd0);
        repeat (3) @(negedge clk);
        check("a_door_c21",  32'(bus.door_open_o), 32'd1);
        @(negedge clk);
        check("a_door_c22",  32'(bus.door_open_o), 32'd0);

        // Reverse from 10 down to 00.
        bus.call_i = 3'b001;
        @(negedge clk); bus.call_i = 3'b000;
        check("b_lamp_c1", 32'(bus.lamp_o),   32'h1);
        check("b_dir_c1",  32'(bus.dir_up_o), 32'd1);
        @(negedge clk);
        check("b_dir_c2",    32'(bus.dir_up_o), 32'd0);
        check("b_moving_c2", 32'(bus.moving_o), 32'd1);
        repeat (8) @(negedge clk);
        check("b_floor_c10", 32'(bus.floor_o), 32'd1);
        repeat (8) @(negedge clk);
        check("b_floor_c18", 32'(bus.floor_o),     32'd0);
        check("b_door_c18",  32'(bus.door_open_o), 32'd1);
        repeat (4) @(negedge clk);

        // Serve the current floor, then reload the dwell with a repeat call.
        bus.call_i = 3'b001;
        @(negedge clk); bus.call_i = 3'b000;
        check("c_lamp_c1", 32'(bus.lamp_o),      32'h1);
        check("c_door_c1", 32'(bus.door_open_o), 32'd0);
        @(negedge clk);
        check("c_door_c2",   32'(bus.door_open_o), 32'd1);
        check("c_lamp_c2",   32'(bus.lamp_o),      32'd0);
        check("c_moving_c2", 32'(bus.moving_o),    32'd0);
        repeat (2) @(negedge clk);
        bus.call_i = 3'b001;
        @(negedge clk); bus.call_i = 3'b000;
        check("c_lamp_c5", 32'(bus.lamp_o), 32'd0);
        repeat (3) @(negedge clk);
        check("c_door_c8", 32'(bus.door_open_o), 32'd1);
        @(negedge clk);
        check("c_door_c9", 32'(bus.door_open_o), 32'd0);

        // Reset mid-travel abandons the move.
        bus.call_i = 3'b100;
        @(negedge clk); bus.call_i = 3'b000;
        repeat (4) @(negedge clk);
        check("d_moving_c5", 32'(bus.moving_o), 32'd1);
        rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        check("d_floor",  32'(bus.floor_o),     32'd0);
        check("d_lamp",   32'(bus.lamp_o),      32'd0);
        check("d_moving", 32'(bus.moving_o),    32'd0);
        check("d_door",   32'(bus.door_open_o), 32'd0);

        for (int i = 0; i < 4000; i++) begin
            bus.call_i = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            rst_n = ($urandom_range(0, 299) != 0);
            @(negedge clk);
        end
        rst_n = 1'b1;
        bus.call_i = 3'b000;
        @(negedge clk);
        #1;
        done = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
